// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN window datapath.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_K          = 3;
  localparam int DEF_MAX_W      = 32;
  localparam int DEF_MAX_H      = 1024;

  // Bits needed to hold any value 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int DEF_CW = cnt_width(DEF_MAX_W);
  localparam int DEF_RW = cnt_width(DEF_MAX_H);

  // Flat index of window element (row i, column j) in a k x k window.
  function automatic int win_idx(input int i, input int j, input int k);
    return i * k + j;
  endfunction

endpackage

// File: rtl/tap_shift_register.sv
// Line delay: MAX_W-entry shift chain advanced only by ce, read at tap_sel.
module tap_shift_register
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_W      = DEF_MAX_W,
  parameter int TW         = $clog2(MAX_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [TW-1:0]         tap_sel,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] stage [MAX_W];

  // Shift one entry per accepted pixel; cleared by reset.
  always_ff @(posedge clk) begin
    // NOTE: this chain is a register array, not a RAM, so clearing it on
    // reset is cheap; a true memory macro could not be reset this way.
    if (rst) begin
      for (int k = 0; k < MAX_W; k++) stage[k] <= '0;
    end else if (ce) begin
      stage[0] <= data_in;
      for (int k = 1; k < MAX_W; k++) stage[k] <= stage[k-1];
    end
  end

  // Tap img_w-1 returns the pixel accepted exactly img_w pushes earlier.
  assign data_out = stage[tap_sel];

endmodule

// File: rtl/window_line_buffer.sv
// Streaming KxK window generator: K-1 line delays feed a KxK register window.
module window_line_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K          = DEF_K,
  parameter int MAX_W      = DEF_MAX_W,
  parameter int MAX_H      = DEF_MAX_H,
  parameter int CW         = cnt_width(MAX_W),
  parameter int RW         = cnt_width(MAX_H)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CW-1:0]             img_w,
  input  logic [RW-1:0]             img_h,
  input  logic                      ce,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic [K*K*DATA_WIDTH-1:0] window_out,
  output logic                      out_valid,
  output logic                      frame_done,
  output logic                      cfg_err,
  output logic                      busy
);

  localparam int TW = $clog2(MAX_W);
  localparam logic [CW-1:0] K_C     = CW'(K);
  localparam logic [CW-1:0] K1_C    = CW'(K - 1);
  localparam logic [CW-1:0] MAX_W_C = CW'(MAX_W);
  localparam logic [RW-1:0] K_R     = RW'(K);
  localparam logic [RW-1:0] K1_R    = RW'(K - 1);
  localparam logic [RW-1:0] MAX_H_R = RW'(MAX_H);

  state_t                state, state_n;
  logic [CW-1:0]         w_q, col;
  logic [RW-1:0]         h_q, row;
  logic                  legal, accept, last_pix;
  logic [TW-1:0]         tap_sel;
  logic [DATA_WIDTH-1:0] row_in [K];
  logic [DATA_WIDTH-1:0] win    [K][K];

  assign legal    = (img_w >= K_C) && (img_w <= MAX_W_C) &&
                    (img_h >= K_R) && (img_h <= MAX_H_R);
  // start takes priority over ce: a pixel arriving with start is dropped.
  assign accept   = (state == RUN) && ce && !start;
  assign last_pix = accept && (col == w_q - CW'(1)) && (row == h_q - RW'(1));
  assign tap_sel  = TW'(w_q - CW'(1));
  assign busy     = (state == RUN);

  // Window row K-1 takes the live pixel; row i takes line delay i, whose
  // input is row i+1's source, giving data_in -> delay K-2 -> ... -> delay 0.
  assign row_in[K-1] = data_in;

  for (genvar d = 0; d < K - 1; d++) begin : g_delay
    tap_shift_register #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_W      (MAX_W),
      .TW         (TW)
    ) u_tap (
      .clk      (clk),
      .rst      (rst),
      .ce       (accept),
      .tap_sel  (tap_sel),
      .data_in  (row_in[d+1]),
      .data_out (row_in[d])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: start (legal or not) overrides pixel flow; last pixel ends RUN.
  always_comb begin
    // NOTE: default first so every path assigns state_n and no latch forms.
    state_n = state;
    if (start)         state_n = legal ? RUN : IDLE;
    else if (last_pix) state_n = DONE;
  end

  // Frame geometry, raster position and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q        <= '0;
      h_q        <= '0;
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      if (start) begin
        if (legal) begin
          w_q <= img_w;
          h_q <= img_h;
          col <= '0;
          row <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (accept) begin
        out_valid  <= (row >= K1_R) && (col >= K1_C);
        frame_done <= last_pix;
        if (col == w_q - CW'(1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Window registers: each row shifts left by one per accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win[i][j] <= '0;
    end else if (accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
        win[i][K-1] <= row_in[i];
      end
    end
  end

  // Flatten the window: element i*K+j, element 0 is the top-left pixel.
  always_comb begin
    window_out = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        window_out[win_idx(i, j, K)*DATA_WIDTH +: DATA_WIDTH] = win[i][j];
  end

endmodule

// File: tb/tb_window_line_buffer.sv
// Self-checking bench for window_line_buffer with a frame-level reference model.
module tb_window_line_buffer;

  localparam int DW    = 16;
  localparam int K     = 3;
  localparam int MAX_W = 8;
  localparam int MAX_H = 16;
  localparam int CW    = $clog2(MAX_W + 1);
  localparam int RW    = $clog2(MAX_H + 1);
  localparam int WW    = K * K * DW;

  logic          clk = 1'b0;
  logic          rst, start, ce;
  logic [CW-1:0] img_w;
  logic [RW-1:0] img_h;
  logic [DW-1:0] data_in;
  logic [WW-1:0] window_out;
  logic          out_valid, frame_done, cfg_err, busy;

  window_line_buffer #(
    .DATA_WIDTH (DW),
    .K          (K),
    .MAX_W      (MAX_W),
    .MAX_H      (MAX_H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .img_w      (img_w),
    .img_h      (img_h),
    .ce         (ce),
    .data_in    (data_in),
    .window_out (window_out),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int h;
    bit err;
    bit bsy;
  } start_vec_t;

  start_vec_t tbl [8];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 run, 2 done; pixels stored in raster order.
  int            m_mode, m_w, m_h, m_n;
  logic [DW-1:0] pix [MAX_W*MAX_H];
  logic [WW-1:0] last_win;
  bit            win_known;

  // Observed DUT statistics for the current frame.
  int            pulses;
  bit            seen_first;
  logic [WW-1:0] first_win, final_win;

  int lst [K*K];

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input int w, input int h);
    return (w >= K) && (w <= MAX_W) && (h >= K) && (h <= MAX_H);
  endfunction

  // Window whose bottom-right pixel is (r,c), taken straight from the image.
  function automatic logic [WW-1:0] model_window(input int r, input int c);
    logic [WW-1:0] v = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        v[(i*K+j)*DW +: DW] = pix[(r-K+1+i)*m_w + (c-K+1+j)];
    return v;
  endfunction

  function automatic logic [WW-1:0] pack_list(input int v [K*K]);
    logic [WW-1:0] p = '0;
    for (int e = 0; e < K*K; e++) p[e*DW +: DW] = DW'(v[e]);
    return p;
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit st, input int w, input int h,
                      input bit cv, input int d);
    bit            e_valid = 1'b0;
    bit            e_done  = 1'b0;
    bit            e_err   = 1'b0;
    bit            acc     = 1'b0;
    int            rr, cc;
    rst = r; start = st; img_w = CW'(w); img_h = RW'(h); ce = cv; data_in = DW'(d);
    if (r) begin
      m_mode = 0; m_n = 0; last_win = '0; win_known = 1'b1;
    end else if (st) begin
      if (is_legal(w, h)) begin
        m_mode = 1; m_w = w; m_h = h; m_n = 0;
      end else begin
        e_err = 1'b1; m_mode = 0;
      end
    end else if (m_mode == 1 && cv) begin
      acc = 1'b1;
      rr  = m_n / m_w;
      cc  = m_n % m_w;
      pix[m_n] = DW'(d);
      if (rr >= K-1 && cc >= K-1) begin
        e_valid = 1'b1; last_win = model_window(rr, cc); win_known = 1'b1;
      end else begin
        win_known = 1'b0;
      end
      if (m_n == m_w*m_h - 1) begin
        e_done = 1'b1; m_mode = 2;
      end
      m_n++;
    end
    @(posedge clk);
    #1;
    check("out_valid",  WW'(out_valid),  WW'(e_valid));
    check("frame_done", WW'(frame_done), WW'(e_done));
    check("cfg_err",    WW'(cfg_err),    WW'(e_err));
    check("busy",       WW'(busy),       WW'(m_mode == 1));
    if (e_valid || (!acc && win_known)) check("window_out", window_out, last_win);
    if (out_valid === 1'b1) begin
      pulses++;
      if (!seen_first) first_win = window_out;
      seen_first = 1'b1;
      final_win  = window_out;
    end
  endtask

  task automatic begin_frame(input int w, input int h, input bit with_ce);
    pulses = 0; seen_first = 1'b0;
    step(1'b0, 1'b1, w, h, with_ce, 999);
  endtask

  // Feed count pixels first, first+1, ... (or random values), with 0..max_gap idle cycles before each.
  task automatic feed(input int first, input int count, input int max_gap, input bit rnd);
    int gaps;
    for (int i = 0; i < count; i++) begin
      gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gaps; g++) step(1'b0, 1'b0, 0, 0, 1'b0, int'($urandom_range(0, 65535)));
      step(1'b0, 1'b0, 0, 0, 1'b1, rnd ? int'($urandom_range(0, 65535)) : first + i);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  // Checks the 4x4 frame of pixels 1..16 against its known windows.
  task automatic check_4x4(input string tag);
    check({tag, " count"}, WW'(pulses), WW'(4));
    lst = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    check({tag, " first"}, first_win, pack_list(lst));
    lst = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
    check({tag, " last"}, final_win, pack_list(lst));
  endtask

  initial begin
    int w, h;
    rst = 1'b1; start = 1'b0; ce = 1'b0; img_w = '0; img_h = '0; data_in = '0;
    m_mode = 0; m_w = 1; m_h = 1; m_n = 0; last_win = '0; win_known = 1'b0;
    pulses = 0; seen_first = 1'b0; first_win = '0; final_win = '0;

    // Reset state, including ce asserted during reset.
    step(1'b1, 1'b0, 0, 0, 1'b0, 0);
    step(1'b1, 1'b1, 4, 4, 1'b1, 5);

    // Start qualification table.
    tbl[0] = '{w: 2, h: 4,  err: 1'b1, bsy: 1'b0};
    tbl[1] = '{w: 9, h: 4,  err: 1'b1, bsy: 1'b0};
    tbl[2] = '{w: 3, h: 3,  err: 1'b0, bsy: 1'b1};
    tbl[3] = '{w: 8, h: 16, err: 1'b0, bsy: 1'b1};
    tbl[4] = '{w: 4, h: 2,  err: 1'b1, bsy: 1'b0};
    tbl[5] = '{w: 4, h: 17, err: 1'b1, bsy: 1'b0};
    tbl[6] = '{w: 8, h: 8,  err: 1'b0, bsy: 1'b1};
    tbl[7] = '{w: 0, h: 0,  err: 1'b1, bsy: 1'b0};
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start = 1'b1; ce = 1'b0; img_w = CW'(tbl[i].w); img_h = RW'(tbl[i].h);
      @(posedge clk);
      #1;
      check("tbl cfg_err",   WW'(cfg_err),   WW'(tbl[i].err));
      check("tbl busy",      WW'(busy),      WW'(tbl[i].bsy));
      check("tbl out_valid", WW'(out_valid), WW'(0));
    end
    start = 1'b0;
    step(1'b1, 1'b0, 0, 0, 1'b0, 0);

    // 4x4 frame, ce held high.
    begin_frame(4, 4, 1'b0);
    feed(1, 16, 0, 1'b0);
    idle(2);
    check_4x4("s1");

    // Same frame with random ce gaps.
    begin_frame(4, 4, 1'b0);
    feed(1, 16, 5, 1'b0);
    idle(1);
    check_4x4("gaps");

    // Full-width frame.
    begin_frame(8, 3, 1'b0);
    feed(1, 24, 0, 1'b0);
    check("w8 count", WW'(pulses), WW'(6));
    lst = '{1, 2, 3, 9, 10, 11, 17, 18, 19};
    check("w8 first", first_win, pack_list(lst));
    lst = '{6, 7, 8, 14, 15, 16, 22, 23, 24};
    check("w8 last", final_win, pack_list(lst));

    // DONE ignores ce; window holds.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, 0, 1'b1, int'($urandom_range(0, 65535)));

    // Illegal widths reject the frame.
    begin_frame(2, 4, 1'b0);
    feed(1, 16, 0, 1'b0);
    check("w2 count", WW'(pulses), WW'(0));
    begin_frame(9, 4, 1'b0);
    feed(1, 16, 0, 1'b0);
    check("w9 count", WW'(pulses), WW'(0));

    // Restart mid-frame.
    begin_frame(4, 4, 1'b0);
    feed(100, 7, 0, 1'b0);
    begin_frame(4, 4, 1'b0);
    feed(1, 16, 0, 1'b0);
    check_4x4("restart");

    // Reset mid-frame; pixels ignored until next start.
    begin_frame(4, 4, 1'b0);
    feed(1, 10, 0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 77);
    pulses = 0;
    feed(50, 6, 0, 1'b0);
    check("post-rst count", WW'(pulses), WW'(0));

    // start together with ce: that pixel is dropped.
    begin_frame(4, 4, 1'b1);
    feed(1, 16, 0, 1'b0);
    check_4x4("start+ce");

    // Random legal frames with random data and gaps.
    for (int f = 0; f < 6; f++) begin
      w = int'($urandom_range(K, MAX_W));
      h = int'($urandom_range(K, 6));
      begin_frame(w, h, 1'b0);
      feed(0, w*h, (f % 2) * 3, 1'b1);
      idle(1);
      check("rand count", WW'(pulses), WW'((w-K+1)*(h-K+1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
